// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit write port between N_REQ
// byte-stream requesters. A grant lasts until the requester marks the last
// byte of a packet, uses up its burst allowance, or leaves valid low for too
// long. One IDLE cycle is spent arbitrating between grants.
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int MAX_BURST     = 16,
  parameter int STALL_TIMEOUT = 64
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     tx_full,
  output logic [7:0]               tx_data,
  output logic                     tx_wr_en,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int IW = $clog2(N_REQ);

  // Terminal counter values: reaching them ends the grant, so neither wraps.
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [9:0] STALL_LAST = 10'(STALL_TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t        state_reg;
  logic [IW-1:0] rr_ptr_reg;
  logic [IW-1:0] grant_reg;
  logic [7:0]    burst_cnt_reg;
  logic [9:0]    stall_cnt_reg;

  // Arbitration candidates in search order: rr_ptr, rr_ptr+1, ... with wrap.
  logic [IW-1:0] cand_idx [N_REQ];
  logic [N_REQ-1:0] cand_hit;
  logic [IW-1:0] pick_idx;
  logic          pick_found;

  // Granted-requester view.
  logic [N_REQ-1:0] gnt_oh;
  logic [7:0]       lane_data [N_REQ];
  logic [7:0]       gnt_data;
  logic             gnt_valid;
  logic             gnt_last;
  logic             xfer_active;
  logic             fire;
  logic             burst_done;
  logic             stall_done;
  logic [IW-1:0]    next_ptr;

  genvar gi;

  // Rotated candidate list; the sum is one bit wider so the wrap test is exact
  // even when N_REQ is not a power of two.
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      logic [IW:0] sum;
      assign sum          = {1'b0, rr_ptr_reg} + (IW+1)'(gi);
      assign cand_idx[gi] = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ))
                                                    : sum[IW-1:0];
      assign cand_hit[gi] = req_valid[cand_idx[gi]];
    end
  endgenerate

  // Pick the first valid candidate; iterating downward lets the lowest
  // rotation offset win.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  // One-hot decode of the grant plus AND-OR byte mux; also drives req_ready.
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign gnt_oh[gi]    = (grant_reg == IW'(gi));
      assign lane_data[gi] = req_data[8*gi +: 8] & {8{gnt_oh[gi]}};
      assign req_ready[gi] = xfer_active & gnt_oh[gi] & ~tx_full;
    end
  endgenerate

  // OR-reduce the masked lanes into the granted byte.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_data = gnt_data | lane_data[i];
    end
  end

  // Reset masks every output in the same cycle, so a grant dropped by reset
  // cannot leak a final write.
  assign xfer_active = (state_reg == XFER) && !Reset;
  assign gnt_valid   = |(req_valid & gnt_oh);
  assign gnt_last    = |(req_last & gnt_oh);
  assign fire        = xfer_active && !tx_full && gnt_valid;
  assign burst_done  = (burst_cnt_reg == BURST_LAST);
  assign stall_done  = (stall_cnt_reg == STALL_LAST);
  assign next_ptr    = (grant_reg == IW'(N_REQ - 1)) ? '0 : grant_reg + 1'b1;

  assign tx_wr_en = fire;
  assign tx_data  = fire ? gnt_data : 8'h00;
  assign grant_id = Reset ? '0 : grant_reg;
  assign busy     = xfer_active;

  // Arbiter FSM: grant selection, burst/stall counting and rotation.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      burst_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            grant_reg     <= pick_idx;
            burst_cnt_reg <= '0;
            stall_cnt_reg <= '0;
            state_reg     <= XFER;
          end
        end
        XFER: begin
          if (fire) begin
            // Last byte and burst cap on the same transfer give one exit.
            if (gnt_last || burst_done) begin
              rr_ptr_reg <= next_ptr;
              state_reg  <= IDLE;
            end else begin
              burst_cnt_reg <= burst_cnt_reg + 8'd1;
              stall_cnt_reg <= '0;
            end
          end else if (!gnt_valid) begin
            // Only an absent byte counts as a stall; tx_full backpressure
            // with valid high leaves the counter alone.
            if (stall_done) begin
              rr_ptr_reg <= next_ptr;
              state_reg  <= IDLE;
            end else begin
              stall_cnt_reg <= stall_cnt_reg + 10'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
